// File: rtl/pixel_prefetch_fifo.sv
// Show-ahead RGB888 pixel FIFO feeding the VGA timing generator; flushes on vsync rise
// and resyncs on the next SOF word. Optional macro: PIXEL_FIFO_UNDERFLOW_COUNT_EN.
module pixel_prefetch_fifo #(
   parameter int C_DEPTH_LOG2 = 4,
   parameter int C_LOW_WATER  = 8
) (
   input  logic                    clk_pixel,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [23:0]             in_data,
   input  logic                    in_sof,
   input  logic                    fetch_next,
   input  logic                    vga_vsync,
   output logic [7:0]              r_o,
   output logic [7:0]              g_o,
   output logic [7:0]              b_o,
   output logic [C_DEPTH_LOG2:0]   level,
   output logic                    req_fill,
   output logic                    underflow,
   output logic [15:0]             underflow_count
);

   localparam int DEPTH = 1 << C_DEPTH_LOG2;
   localparam int LW    = C_DEPTH_LOG2 + 1;

   typedef enum logic {SYNC, RUN} state_t;

   state_t                  state, state_nxt;
   logic [23:0]             mem [DEPTH];
   logic [C_DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_addr;
   logic [LW-1:0]           level_q;
   logic                    vsync_d;
   logic                    flush, full, empty;
   logic                    wr_acc, wr_en, rd_en, uf_evt;
   logic                    underflow_q;
   logic [23:0]             head;

   assign full   = (level_q == LW'(DEPTH));
   assign empty  = (level_q == '0);
   assign flush  = vga_vsync && !vsync_d;
   assign wr_acc = in_valid && in_ready;

   // Outside RUN (or in the flush cycle) only an SOF word is stored; others are drained.
   assign wr_en   = wr_acc && ((state == RUN && !flush) || in_sof);
   assign rd_en   = fetch_next && !empty && !flush;
   assign uf_evt  = fetch_next && empty && !flush;
   assign wr_addr = flush ? '0 : wr_ptr;

   always_ff @(posedge clk_pixel or negedge rst) begin
      if (!rst) vsync_d <= 1'b0;
      else      vsync_d <= vga_vsync;
   end

   always_ff @(posedge clk_pixel) begin
      if (wr_en) mem[wr_addr] <= in_data;
   end

   always_ff @(posedge clk_pixel or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else if (flush) begin
         wr_ptr  <= wr_en ? C_DEPTH_LOG2'(1) : '0;
         rd_ptr  <= '0;
         level_q <= wr_en ? LW'(1) : '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // FSM: state register
   always_ff @(posedge clk_pixel or negedge rst) begin
      if (!rst) state <= SYNC;
      else      state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      if (flush)                      state_nxt = wr_en ? RUN : SYNC;
      else if (state == SYNC && wr_en) state_nxt = RUN;
   end

   // FSM: outputs
   always_comb begin
      in_ready = 1'b1;
      req_fill = 1'b1;
      if (state == RUN) begin
         in_ready = !full;
         req_fill = (level_q <= LW'(C_LOW_WATER));
      end
   end

   always_ff @(posedge clk_pixel or negedge rst) begin
      if (!rst)        underflow_q <= 1'b0;
      else if (uf_evt) underflow_q <= 1'b1;
   end

`ifdef PIXEL_FIFO_UNDERFLOW_COUNT_EN
   logic [15:0] uf_cnt;
   always_ff @(posedge clk_pixel or negedge rst) begin
      if (!rst)                             uf_cnt <= '0;
      else if (uf_evt && uf_cnt != 16'hFFFF) uf_cnt <= uf_cnt + 16'd1;
   end
   assign underflow_count = uf_cnt;
`else
   assign underflow_count = 16'h0000;
`endif

   assign head      = empty ? 24'h000000 : mem[rd_ptr];
   assign r_o       = head[23:16];
   assign g_o       = head[15:8];
   assign b_o       = head[7:0];
   assign level     = level_q;
   assign underflow = underflow_q;

endmodule

// File: doc/pixel_prefetch_fifo.md
# pixel_prefetch_fifo

Show-ahead pixel FIFO that sits directly upstream of the VGA timing generator and drives its `r_i`/`g_i`/`b_i` inputs. The head pixel is always on the outputs before the timing generator consumes it with its one-cycle `fetch_next` pulse. The block accepts RGB888 words from the framebuffer reader over a valid/ready handshake and raises a refill request at a low-water mark. It resynchronises to the frame on every rising edge of vsync.

## Interface
Parameters:
- `C_DEPTH_LOG2`, 4: log2 of FIFO depth (16 entries).
- `C_LOW_WATER`, 8: `req_fill` asserted while level <= this value.

Ports:
- `clk_pixel`  in  1  pixel clock; the only clock in the block.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  24  pixel word `{r[7:0], g[7:0], b[7:0]}`.
- `in_sof`  in  1  word is the first pixel of a frame.
- `fetch_next`  in  1  head pixel consumed (1-cycle pulse from the timing generator).
- `vga_vsync`  in  1  vsync from the timing generator; its rising edge triggers a flush.
- `r_o`, `g_o`, `b_o`  out  8 each  head pixel, show-ahead.
- `level`  out  `C_DEPTH_LOG2`+1  current occupancy, 0..2^`C_DEPTH_LOG2`.
- `req_fill`  out  1  refill request to the framebuffer reader.
- `underflow`  out  1  sticky flag: a fetch occurred while the FIFO was empty.
- `underflow_count`  out  16  saturating count of underflow events.

## Operation
Storage and pointers:
- Register array of 2^`C_DEPTH_LOG2` x 24 bits.
- `wr_ptr`/`rd_ptr` are `C_DEPTH_LOG2` bits wide and wrap modulo depth.
- `level` is tracked explicitly.
- full = (`level` == depth); empty = (`level` == 0).

Write and read:
- `in_ready` = !full. This is a combinational function of registered state and does not depend on `fetch_next`.
- Write occurs when `in_valid && in_ready`.
- Read occurs when `fetch_next && !empty`: `rd_ptr` advances and `level` decrements.
- Simultaneous write and read leaves `level` unchanged.
- Outputs = `mem[rd_ptr]` when not empty, else 0x000000.

Underflow:
- An underflow event is `fetch_next && empty`, outside a flush cycle.
- On an underflow event: no pointer change, `underflow` sets, and `underflow_count` increments, saturating at 0xFFFF.
- A write and an underflow in the same cycle: the write lands, `level` becomes 1, and the underflow is still counted.

State machine, two states:
- SYNC: `in_ready` = 1, regardless of full. Words with `in_sof`=0 are accepted and discarded. A word with `in_sof`=1 is written and the state goes to RUN.
- RUN: normal FIFO operation. `in_sof` is ignored, and the word is stored normally.

Flush:
- Rising edge of `vga_vsync` is detected against a registered copy of the previous value (`vsync_d`).
- In the flush cycle: `wr_ptr`, `rd_ptr` and `level` return to 0, and the state goes to SYNC.
- `fetch_next` in the flush cycle is ignored and is not counted as an underflow.
- An `in_sof`=1 word in the flush cycle is written to entry 0 (level 1, state RUN).
- An `in_sof`=0 word in the flush cycle is discarded.

Refill request and sticky flags:
- `req_fill` = (state == RUN) && (`level` <= `C_LOW_WATER`), or (state == SYNC).
- `underflow` and `underflow_count` are cleared only by `rst`. A flush does not clear them.

## Timing
Reset values (while `rst`=0):
- Pointers and `level` = 0; state = SYNC; `vsync_d` = 0.
- `in_ready` = 1; `req_fill` = 1.
- `underflow` = 0; `underflow_count` = 0.
- `r_o`/`g_o`/`b_o` = 0.
- Memory contents are not reset.

Latency:
- A word written at edge N is on `r_o`/`g_o`/`b_o` after edge N if the FIFO was empty. Otherwise it becomes the head after the preceding entries are read.
- `fetch_next` at edge N exposes the next entry after edge N.
- Vsync rising at the input before edge N: the flush takes effect at edge N, so `level` = 0 (or 1 if an SOF word was written) after N.

Other timing rules:
- `in_ready` drops the cycle after the write that fills the FIFO. It rises the cycle after the read that frees an entry.
- `rst` asserted mid-operation returns all state to reset values immediately. Data in flight is lost.

## Configuration
- `PIXEL_FIFO_UNDERFLOW_COUNT_EN` defined: the 16-bit saturating `underflow_count` register is built as described above.
- Not defined: no counter register; `underflow_count` is tied to 0.
- The sticky `underflow` flag is present in both builds.

## Test plan
- **Reset/SOF gating:** after reset, push 3 words with `in_sof`=0 then 0x112233 with `in_sof`=1 -> `level`=1, `r_o`=0x11, `g_o`=0x22, `b_o`=0x33, state RUN, first 3 words dropped.
- **Fill to full:** push 16 words in RUN with no fetch -> `level`=16, `in_ready`=0, 17th word not accepted; one `fetch_next` -> `in_ready`=1 next cycle and head advances to word 2.
- **Low water:** with `level`=9, one fetch -> `level`=8, `req_fill` goes 0->1; 8 more fetches -> `level`=0, outputs 0x000000.
- **Underflow:** `fetch_next` while empty, twice -> `underflow`=1, `underflow_count`=2 (0 with macro undefined); a simultaneous write and fetch while empty -> `level`=1 and count=3.
- **Vsync flush:** `level`=10, then vsync rises together with a `fetch_next` and an `in_sof`=0 word -> next cycle `level`=0, state SYNC, count unchanged, word discarded.
- **Pointer wrap:** stream 40 sequential words with interleaved fetches keeping `level` between 4 and 12 -> outputs match the input sequence in order, no loss across the 16-entry wrap.
